pwm_capture: RTL

Measures an incoming PWM waveform and reports its period and high time in `clk_in` cycles. It pairs with the team's clock/PWM generators: it is the receive-side check that a generated waveform has the intended frequency and duty. It sits on the fabric clock and takes an asynchronous `pwm_in` pin or an internal PWM net. Software-visible registers or an LED/debug path consume the results.

---
 rtl/pwm_capture_pkg.sv | 17 +
 rtl/pwm_capture_if.sv | 41 ++++
 rtl/pwm_capture_sync_edge.sv | 34 +++
 rtl/pwm_capture.sv | 113 +++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  // Capture state machine encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

  // Default counter width for period/high-time measurement
  localparam int PWM_CNT_W = 28;

  // Default loss-of-signal timeout in clk_in cycles
  localparam logic [PWM_CNT_W-1:0] PWM_TIMEOUT = 28'd50_000_000;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bundle of the PWM capture block.
//
// Handshake: meas_valid is a valid-only strobe with no ready. period_out and
// high_out are updated in the meas_valid cycle and held until the next one;
// a consumer must take the values in that cycle. timeout is a single-cycle
// strobe marking loss of signal. locked is a level. state and pwm_level are
// debug views of the capture FSM and the synchronized input.
interface pwm_capture_if #(
  parameter int CNT_W = pwm_pkg::PWM_CNT_W
);
  import pwm_pkg::*;

  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
  cap_state_t       state;
  logic             pwm_level;

  modport master (
    output period_out,
    output high_out,
    output meas_valid,
    output locked,
    output timeout,
    output state,
    output pwm_level
  );

  modport slave (
    input period_out,
    input high_out,
    input meas_valid,
    input locked,
    input timeout,
    input state,
    input pwm_level
  );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer plus history flop with rise/fall detection for an
// asynchronous single-bit input. Both edges see identical delay, so pulse
// widths measured downstream are exact for a clean input.
module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain (s1, s2) and one-cycle history (s3)
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of pwm_in in clk_in cycles,
// reports each completed period with a one-cycle meas_valid, and flags loss
// of signal when no rising edge arrives within TIMEOUT cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int               CNT_W   = PWM_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(PWM_TIMEOUT)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          pwm_in,
  pwm_capture_if.master res
);

  logic level;
  logic rise;
  logic fall;

  sync_edge u_sync_edge (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (pwm_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  cap_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcap_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             meas_valid_q;
  logic             locked_q;
  logic             timeout_q;
  logic             at_limit;

  // cnt is the number of cycles since the last detected rise
  assign at_limit = (cnt_q == TIMEOUT);

  // Capture FSM with counter, high-time capture and registered outputs.
  // A rise always takes priority over an expiring timeout so a period of
  // exactly TIMEOUT cycles still completes as a measurement.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcap_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Falls are ignored here; only a rise starts a period
          if (rise) begin
            cnt_q   <= CNT_W'(1);
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (at_limit) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (fall) begin
              hcap_q  <= cnt_q;
              state_q <= LOW;
            end
          end
        end
        LOW: begin
          if (rise) begin
            period_q     <= cnt_q;
            high_q       <= hcap_q;
            meas_valid_q <= 1'b1;
            locked_q     <= 1'b1;
            cnt_q        <= CNT_W'(1);
            state_q      <= HIGH;
          end else if (at_limit) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res.period_out = period_q;
  assign res.high_out   = high_q;
  assign res.meas_valid = meas_valid_q;
  assign res.locked     = locked_q;
  assign res.timeout    = timeout_q;
  assign res.state      = state_q;
  assign res.pwm_level  = level;

endmodule
